// File: rtl/stream_demux_pkg.sv
// Shared types and helpers for the 1-to-N stream demultiplexer.
// Optional auto-select build: STREAM_DEMUX_AUTO_SEL_EN.
package stream_demux_pkg;

    localparam int DCW_DEF = 8;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } chan_state_e;

    function automatic int sel_w(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/stream_demux_chan.sv
// One-entry holding register for a single output channel.
// Data stays stable while valid until the consumer takes it.
module stream_demux_chan
    import stream_demux_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en_i,
    input  logic [W-1:0] wr_data_i,
    input  logic         rd_ready_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic         wr_rdy_o
);

    chan_state_e  state_q;
    logic [W-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (wr_en_i) begin
                        state_q <= FULL;
                        data_q  <= wr_data_i;
                    end
                end
                FULL: begin
                    // a write on the drain edge refills in place
                    if (wr_en_i) begin
                        data_q <= wr_data_i;
                    end else if (rd_ready_i) begin
                        state_q <= EMPTY;
                    end
                end
                default: begin
                    state_q <= EMPTY;
                end
            endcase
        end
    end

    assign valid_o  = (state_q == FULL);
    assign data_o   = data_q;
    assign wr_rdy_o = (state_q == EMPTY) || rd_ready_i;

endmodule

// File: rtl/stream_demux1ton.sv
// Registered 1-to-N valid/ready stream demultiplexer with drop counting.
// Define STREAM_DEMUX_AUTO_SEL_EN for round-robin destination (adds cur_sel).
module stream_demux1ton
    import stream_demux_pkg::*;
#(
    parameter  int N   = 4,
    parameter  int W   = 8,
    parameter  int DCW = DCW_DEF,
    localparam int SW  = sel_w(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [W-1:0]   in_data,
    input  logic [SW-1:0]  in_sel,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [N*W-1:0] out_data,
    output logic [N-1:0]   out_valid,
    input  logic [N-1:0]   out_ready,
`ifdef STREAM_DEMUX_AUTO_SEL_EN
    output logic [SW-1:0]  cur_sel,
`endif
    output logic [DCW-1:0] drop_cnt,
    output logic           sel_err
);

    logic [SW-1:0]  sel;
    logic           sel_ok;
    logic [N-1:0]   chan_rdy;
    logic [N-1:0]   hit;
    logic [N-1:0]   wr_en;
    logic           tgt_rdy;
    logic           accept;
    logic           drop;
    logic [DCW-1:0] drop_cnt_q;
    logic [DCW-1:0] drop_cnt_d;
    logic           sel_err_q;

`ifdef STREAM_DEMUX_AUTO_SEL_EN
    logic [SW-1:0] cnt_q;
    logic [SW-1:0] cnt_d;
    logic          unused_sel;

    assign unused_sel = ^in_sel;
    assign sel        = cnt_q;
    assign sel_ok     = 1'b1;
    assign cur_sel    = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = (cnt_q == SW'(N - 1)) ? '0 : cnt_q + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign sel    = in_sel;
    assign sel_ok = 32'(in_sel) < 32'(N);
`endif

    // out-of-range selects match no channel and are always ready
    always_comb begin
        hit     = '0;
        tgt_rdy = 1'b1;
        for (int k = 0; k < N; k++) begin
            if (sel_ok && (sel == SW'(k))) begin
                hit[k]  = 1'b1;
                tgt_rdy = chan_rdy[k];
            end
        end
    end

    assign in_ready = rst_n && tgt_rdy;
    assign accept   = in_valid && in_ready;
    assign wr_en    = hit & {N{accept}};
    assign drop     = accept && !sel_ok;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && !(&drop_cnt_q)) begin
            drop_cnt_d = drop_cnt_q + DCW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
            sel_err_q  <= 1'b0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
            sel_err_q  <= drop;
        end
    end

    assign drop_cnt = drop_cnt_q;
    assign sel_err  = sel_err_q;

    for (genvar k = 0; k < N; k++) begin : g_chan
        stream_demux_chan #(
            .W(W)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .wr_en_i   (wr_en[k]),
            .wr_data_i (in_data),
            .rd_ready_i(out_ready[k]),
            .valid_o   (out_valid[k]),
            .data_o    (out_data[k*W +: W]),
            .wr_rdy_o  (chan_rdy[k])
        );
    end

endmodule

// File: tb/tb_stream_demux1ton.sv
// Bench for stream_demux1ton: vector table, per-channel scoreboard,
// drop saturation on an N=3 instance, async reset, auto-select build.
module tb_stream_demux1ton;

    typedef struct {
        logic       vld;
        logic [1:0] sel;
        logic [7:0] data;
        logic [3:0] rdy;
        logic       irdy;
        logic [3:0] ov;
        logic [7:0] od;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [7:0]  in_data;
    logic [1:0]  in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [7:0]  drop_cnt;
    logic        sel_err;

    logic [7:0]  d3_data;
    logic [1:0]  d3_sel;
    logic        d3_valid;
    logic        d3_ready;
    logic [23:0] d3_odata;
    logic [2:0]  d3_ovalid;
    logic [2:0]  d3_ordy;
    logic [7:0]  d3_drop;
    logic        d3_err;

    logic [1:0]  mon_sel;
    logic [7:0]  sbq[4][$];
    int          total;
    int          bad;
    int          exp_drop;
    vec_t        tbl[14];

`ifdef STREAM_DEMUX_AUTO_SEL_EN
    logic [1:0] cur_sel;
    logic [1:0] d3_cur;
    assign mon_sel = cur_sel;
`else
    assign mon_sel = in_sel;
`endif

    stream_demux1ton #(.N(4), .W(8), .DCW(8)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
`ifdef STREAM_DEMUX_AUTO_SEL_EN
        .cur_sel  (cur_sel),
`endif
        .drop_cnt (drop_cnt),
        .sel_err  (sel_err)
    );

    stream_demux1ton #(.N(3), .W(8), .DCW(8)) u_dut3 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (d3_data),
        .in_sel   (d3_sel),
        .in_valid (d3_valid),
        .in_ready (d3_ready),
        .out_data (d3_odata),
        .out_valid(d3_ovalid),
        .out_ready(d3_ordy),
`ifdef STREAM_DEMUX_AUTO_SEL_EN
        .cur_sel  (d3_cur),
`endif
        .drop_cnt (d3_drop),
        .sel_err  (d3_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] s,
                         input logic [7:0] d, input logic [3:0] r);
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = r;
    endtask

    // handshakes are judged at the negedge before the edge that takes them
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 4; k++) begin
                if (out_valid[k] && out_ready[k]) begin
                    if (sbq[k].size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL sb_underflow ch=%0d act=%0h exp=none",
                                 k, out_data[k*8 +: 8]);
                    end else begin
                        chk("sb_data", 32'(out_data[k*8 +: 8]),
                            32'(sbq[k].pop_front()));
                    end
                end
            end
            if (in_valid && in_ready) begin
                sbq[mon_sel].push_back(in_data);
            end
            if (d3_valid && d3_ready && d3_sel == 2'd3) begin
                exp_drop = (exp_drop == 255) ? 255 : exp_drop + 1;
            end
        end
    end

    initial begin
        total    = 0;
        bad      = 0;
        exp_drop = 0;
        rst_n    = 1'b0;
        drive(1'b0, 2'd0, 8'h00, 4'h0);
        d3_valid = 1'b0;
        d3_sel   = 2'd0;
        d3_data  = 8'h00;
        d3_ordy  = 3'b111;

        tbl[0]  = '{1'b1, 2'd0, 8'hA1, 4'hF, 1'b1, 4'b0001, 8'hA1};
        tbl[1]  = '{1'b1, 2'd1, 8'hB2, 4'hF, 1'b1, 4'b0010, 8'hB2};
        tbl[2]  = '{1'b1, 2'd2, 8'hC3, 4'hF, 1'b1, 4'b0100, 8'hC3};
        tbl[3]  = '{1'b1, 2'd3, 8'hD4, 4'hF, 1'b1, 4'b1000, 8'hD4};
        tbl[4]  = '{1'b1, 2'd2, 8'h11, 4'hB, 1'b1, 4'b0100, 8'h11};
        tbl[5]  = '{1'b1, 2'd2, 8'h22, 4'hB, 1'b0, 4'b0100, 8'h11};
        tbl[6]  = '{1'b1, 2'd0, 8'h33, 4'hB, 1'b1, 4'b0101, 8'h33};
        tbl[7]  = '{1'b1, 2'd2, 8'h22, 4'hB, 1'b0, 4'b0100, 8'h11};
        tbl[8]  = '{1'b1, 2'd2, 8'h22, 4'hF, 1'b1, 4'b0100, 8'h22};
        tbl[9]  = '{1'b0, 2'd0, 8'h00, 4'hF, 1'b1, 4'b0000, 8'h00};
        tbl[10] = '{1'b1, 2'd1, 8'h55, 4'hD, 1'b1, 4'b0010, 8'h55};
        tbl[11] = '{1'b1, 2'd1, 8'h66, 4'hD, 1'b0, 4'b0010, 8'h55};
        tbl[12] = '{1'b1, 2'd1, 8'h66, 4'hF, 1'b1, 4'b0010, 8'h66};
        tbl[13] = '{1'b0, 2'd0, 8'h00, 4'hF, 1'b1, 4'b0000, 8'h00};

        #3;
        chk("rst_irdy", 32'(in_ready), 32'd0);
        chk("rst_ov", 32'(out_valid), 32'd0);
        chk("rst_od", out_data, 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        chk("rst_err", 32'(sel_err), 32'd0);
        chk("rst_irdy3", 32'(d3_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

`ifdef STREAM_DEMUX_AUTO_SEL_EN
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 2'd3, 8'(i + 1), 4'hF);
            #1;
            chk("cur_sel", 32'(cur_sel), 32'(i % 4));
            chk("auto_irdy", 32'(in_ready), 32'd1);
            @(posedge clk);
            #1;
            chk("auto_ov", 32'(out_valid), 32'(1 << (i % 4)));
            chk("auto_od", 32'(out_data[(i % 4)*8 +: 8]), 32'(i + 1));
            chk("auto_err", 32'(sel_err), 32'd0);
        end
        drive(1'b0, 2'd3, 8'h00, 4'hF);
        #1;
        chk("auto_wrap", 32'(cur_sel), 32'd2);
        @(posedge clk);
        #1;
        chk("auto_drop", 32'(drop_cnt), 32'd0);
`else
        foreach (tbl[i]) begin
            drive(tbl[i].vld, tbl[i].sel, tbl[i].data, tbl[i].rdy);
            #1;
            chk($sformatf("irdy[%0d]", i), 32'(in_ready), 32'(tbl[i].irdy));
            @(posedge clk);
            #1;
            chk($sformatf("ov[%0d]", i), 32'(out_valid), 32'(tbl[i].ov));
            if (tbl[i].ov[tbl[i].sel]) begin
                chk($sformatf("od[%0d]", i),
                    32'(out_data[tbl[i].sel*8 +: 8]), 32'(tbl[i].od));
            end
        end

        d3_valid = 1'b1;
        d3_sel   = 2'd3;
        d3_data  = 8'h5A;
        #1;
        chk("inv_irdy", 32'(d3_ready), 32'd1);
        @(posedge clk);
        #1;
        d3_valid = 1'b0;
        chk("inv_err", 32'(d3_err), 32'd1);
        chk("inv_drop", 32'(d3_drop), 32'(exp_drop));
        chk("inv_drop1", 32'(d3_drop), 32'd1);
        chk("inv_ov", 32'(d3_ovalid), 32'd0);
        @(posedge clk);
        #1;
        chk("inv_err_end", 32'(d3_err), 32'd0);
        d3_valid = 1'b1;
        repeat (299) @(posedge clk);
        #1;
        d3_valid = 1'b0;
        chk("sat_model", 32'(d3_drop), 32'(exp_drop));
        chk("sat_drop", 32'(d3_drop), 32'd255);
        chk("sat_ov", 32'(d3_ovalid), 32'd0);

        drive(1'b1, 2'd0, 8'h77, 4'h0);
        @(posedge clk);
        #1;
        drive(1'b1, 2'd3, 8'h88, 4'h0);
        @(posedge clk);
        #1;
        chk("pre_rst_ov", 32'(out_valid), 32'b1001);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ov", 32'(out_valid), 32'd0);
        chk("mid_rst_od", out_data, 32'd0);
        chk("mid_rst_drop", 32'(d3_drop), 32'd0);
        chk("mid_rst_irdy", 32'(in_ready), 32'd0);
        for (int k = 0; k < 4; k++) sbq[k].delete();
        exp_drop = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_ov", 32'(out_valid), 32'd0);
        drive(1'b1, 2'd1, 8'h9A, 4'hF);
        #1;
        chk("post_rst_irdy", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("post_rst_ov1", 32'(out_valid), 32'b0010);
        chk("post_rst_od1", 32'(out_data[15:8]), 32'h9A);
`endif
        @(posedge clk);
        #1;
        chk("drained", 32'(out_valid), 32'd0);
        chk("sb_left", 32'(sbq[0].size() + sbq[1].size() +
                             sbq[2].size() + sbq[3].size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
